// File: rtl/rsa_stage_seq.sv
// Stage sequencer for the reconfigurable systolic array: one-hot stage accept, row-block sweep, nonlinear send/receive handshake.
// Optional watchdog on the nonlinear handshakes is enabled by defining RSA_STAGE_TIMEOUT_EN.
module rsa_stage_seq #(
    parameter int STAGE_NUM    = 3,
    parameter int BLK          = 4,
    parameter int ROW_LEN      = 10,
    parameter int MAX_LANDMARK = 500,
    parameter int TIMEOUT_W    = 8
) (
    input  logic                 clk,
    input  logic                 sys_rst,
    input  logic [ROW_LEN-1:0]   landmark_num,
    input  logic [STAGE_NUM-1:0] stage_val,
    output logic [STAGE_NUM-1:0] stage_rdy,
    output logic                 tile_val,
    input  logic                 tile_rdy,
    output logic [ROW_LEN-1:0]   blk_idx,
    output logic [STAGE_NUM-1:0] nonlinear_m_val,
    input  logic [STAGE_NUM-1:0] nonlinear_m_rdy,
    input  logic [STAGE_NUM-1:0] nonlinear_s_val,
    output logic [STAGE_NUM-1:0] nonlinear_s_rdy,
    output logic [STAGE_NUM-1:0] stage_done,
    output logic                 busy,
    output logic                 err
);

    localparam int SHIFT = $clog2(BLK);
    localparam int NW    = ROW_LEN + 2;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        NL_SEND,
        NL_RECV,
        DONE
    } state_e;

    state_e               state_q, state_d;
    logic [STAGE_NUM-1:0] sel_q, sel_d;
    logic [NW-1:0]        nblk_q, nblk_d;
    logic [ROW_LEN-1:0]   blk_idx_q, blk_idx_d;
    logic                 tile_val_q, tile_val_d;
    logic [STAGE_NUM-1:0] m_val_q, m_val_d;
    logic [STAGE_NUM-1:0] s_rdy_q, s_rdy_d;
    logic [STAGE_NUM-1:0] done_q, done_d;
    logic [STAGE_NUM-1:0] stage_rdy_q, stage_rdy_d;
    logic                 busy_q, busy_d;

    logic [STAGE_NUM-1:0] pick;
    logic [ROW_LEN-1:0]   nlm;
    logic [NW-1:0]        blk_sum;
    logic [NW-1:0]        nblk_calc;
    logic                 last_blk;
    logic                 m_hit;
    logic                 s_hit;

    // Lowest set request bit wins: x & -x isolates it.
    assign pick      = stage_val & (~stage_val + STAGE_NUM'(1));
    assign nlm       = (landmark_num > ROW_LEN'(MAX_LANDMARK)) ? ROW_LEN'(MAX_LANDMARK) : landmark_num;
    assign blk_sum   = NW'(3) + {1'b0, nlm, 1'b0} + NW'(BLK - 1);
    assign nblk_calc = blk_sum >> SHIFT;
    assign last_blk  = ({2'b00, blk_idx_q} == (nblk_q - NW'(1)));
    assign m_hit     = |(nonlinear_m_rdy & sel_q);
    assign s_hit     = |(nonlinear_s_val & sel_q);

`ifdef RSA_STAGE_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] tmo_q, tmo_d;
    logic                 err_q, err_d;
    logic                 waiting;

    assign waiting = ((state_q == NL_SEND) && !m_hit) || ((state_q == NL_RECV) && !s_hit);
`else
    logic unused_tmo_w;

    assign unused_tmo_w = |TIMEOUT_W;
`endif

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        nblk_d    = nblk_q;
        blk_idx_d = blk_idx_q;

        case (state_q)
            IDLE: begin
                if (|stage_val) begin
                    state_d   = ISSUE;
                    sel_d     = pick;
                    nblk_d    = nblk_calc;
                    blk_idx_d = '0;
                end
            end
            ISSUE: begin
                if (tile_rdy) begin
                    blk_idx_d = blk_idx_q + ROW_LEN'(1);
                    if (last_blk) begin
                        state_d = NL_SEND;
                    end
                end
            end
            NL_SEND: begin
                if (m_hit) begin
                    state_d = NL_RECV;
                end
            end
            NL_RECV: begin
                if (s_hit) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

`ifdef RSA_STAGE_TIMEOUT_EN
        tmo_d = tmo_q;
        err_d = err_q;
        // The watchdog restarts on every state change, so each handshake gets its own budget.
        if (state_d != state_q) begin
            tmo_d = '0;
        end else if (waiting) begin
            tmo_d = tmo_q + TIMEOUT_W'(1);
            if (tmo_d == '1) begin
                err_d   = 1'b1;
                state_d = IDLE;
            end
        end
`endif

        tile_val_d  = (state_d == ISSUE);
        m_val_d     = (state_d == NL_SEND) ? sel_d : '0;
        s_rdy_d     = (state_d == NL_RECV) ? sel_d : '0;
        done_d      = (state_d == DONE) ? sel_d : '0;
        stage_rdy_d = {STAGE_NUM{state_d == IDLE}};
        busy_d      = (state_d != IDLE);
    end

    // Outputs are registered alongside the state so they always match state_q.
    always_ff @(posedge clk or negedge sys_rst) begin
        if (!sys_rst) begin
            state_q     <= IDLE;
            sel_q       <= '0;
            nblk_q      <= '0;
            blk_idx_q   <= '0;
            tile_val_q  <= 1'b0;
            m_val_q     <= '0;
            s_rdy_q     <= '0;
            done_q      <= '0;
            stage_rdy_q <= '1;
            busy_q      <= 1'b0;
`ifdef RSA_STAGE_TIMEOUT_EN
            tmo_q       <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            nblk_q      <= nblk_d;
            blk_idx_q   <= blk_idx_d;
            tile_val_q  <= tile_val_d;
            m_val_q     <= m_val_d;
            s_rdy_q     <= s_rdy_d;
            done_q      <= done_d;
            stage_rdy_q <= stage_rdy_d;
            busy_q      <= busy_d;
`ifdef RSA_STAGE_TIMEOUT_EN
            tmo_q       <= tmo_d;
            err_q       <= err_d;
`endif
        end
    end

    assign stage_rdy       = stage_rdy_q;
    assign tile_val        = tile_val_q;
    assign blk_idx         = blk_idx_q;
    assign nonlinear_m_val = m_val_q;
    assign nonlinear_s_rdy = s_rdy_q;
    assign stage_done      = done_q;
    assign busy            = busy_q;

`ifdef RSA_STAGE_TIMEOUT_EN
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_rsa_stage_seq.sv
// Directed self-checking bench for rsa_stage_seq; expected block counts and latencies are hand-computed.
module tb_rsa_stage_seq;

    logic       clk;
    logic       sys_rst;
    logic [9:0] landmark_num;
    logic [2:0] stage_val;
    logic [2:0] stage_rdy;
    logic       tile_val;
    logic       tile_rdy;
    logic [9:0] blk_idx;
    logic [2:0] nonlinear_m_val;
    logic [2:0] nonlinear_m_rdy;
    logic [2:0] nonlinear_s_val;
    logic [2:0] nonlinear_s_rdy;
    logic [2:0] stage_done;
    logic       busy;
    logic       err;

    int tests = 0;
    int fails = 0;

    int       w_tiles;
    bit       w_blk_ok;
    int       w_mcnt;
    logic [2:0] w_mval;
    int       w_done_cnt;
    int       w_done_edge;
    logic [2:0] w_done_val;
    bit       w_rdy_bad;
    int       w_err_edge;

    rsa_stage_seq #(
        .STAGE_NUM(3),
        .BLK(4),
        .ROW_LEN(10),
        .MAX_LANDMARK(500),
        .TIMEOUT_W(4)
    ) dut (
        .clk(clk),
        .sys_rst(sys_rst),
        .landmark_num(landmark_num),
        .stage_val(stage_val),
        .stage_rdy(stage_rdy),
        .tile_val(tile_val),
        .tile_rdy(tile_rdy),
        .blk_idx(blk_idx),
        .nonlinear_m_val(nonlinear_m_val),
        .nonlinear_m_rdy(nonlinear_m_rdy),
        .nonlinear_s_val(nonlinear_s_val),
        .nonlinear_s_rdy(nonlinear_s_rdy),
        .stage_done(stage_done),
        .busy(busy),
        .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] time limit");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        stage_val       = '0;
        tile_rdy        = 1'b0;
        nonlinear_m_rdy = '0;
        nonlinear_s_val = '0;
    endtask

    task automatic accept(input logic [2:0] sv, input logic [9:0] lm);
        landmark_num = lm;
        stage_val    = sv;
        tick();
        stage_val = '0;
    endtask

    // Observes one stage run (c = edges since the accept edge) and drives the datapath/nonlinear side.
    task automatic watch(input int max_cyc, input bit toggle, input int m_delay,
                         input logic [2:0] sval, input logic [2:0] stray);
        int t_obs;
        int hs;
        w_tiles = 0; w_blk_ok = 1; w_mcnt = 0; w_mval = '0; w_done_cnt = 0;
        w_done_edge = -1; w_done_val = '0; w_rdy_bad = 0; w_err_edge = -1;
        t_obs = 0; hs = 0;
        for (int c = 0; c < max_cyc; c++) begin
            if (stage_done != 3'b000) begin
                w_done_cnt++;
                if (w_done_edge < 0) begin
                    w_done_edge = c + 1;
                    w_done_val  = stage_done;
                end
            end
            if (busy && stage_rdy != 3'b000) w_rdy_bad = 1;
            if (err && w_err_edge < 0) w_err_edge = c;
            if (tile_val) begin
                if (blk_idx !== 10'(hs)) w_blk_ok = 0;
                t_obs++;
                tile_rdy = toggle ? t_obs[0] : 1'b1;
                if (tile_rdy) hs++;
            end else begin
                tile_rdy = 1'b0;
            end
            if (nonlinear_m_val != 3'b000) begin
                w_mcnt++;
                w_mval |= nonlinear_m_val;
                nonlinear_m_rdy = (w_mcnt > m_delay) ? 3'b111 : ~nonlinear_m_val;
            end else begin
                nonlinear_m_rdy = 3'b000;
            end
            nonlinear_s_val = sval;
            stage_val = (busy && stage_done == 3'b000) ? stray : 3'b000;
            if ((w_done_cnt > 0 && stage_done == 3'b000) || w_err_edge >= 0) break;
            tick();
        end
        w_tiles = hs;
        idle_inputs();
    endtask

    task automatic test_reset();
        idle_inputs();
        landmark_num = '0;
        sys_rst = 1'b0;
        tick();
        tick();
        sys_rst = 1'b1;
        tick();
        tests++; if (stage_rdy !== 3'b111) begin fails++; $display("[TB] FAIL reset_stage_rdy got %b expected 111", stage_rdy); end
        tests++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL reset_busy got %b expected 0", busy); end
        tests++; if (tile_val !== 1'b0 || blk_idx !== 10'd0) begin fails++; $display("[TB] FAIL reset_tile got val=%b idx=%0d expected 0/0", tile_val, blk_idx); end
        tests++; if (nonlinear_m_val !== 3'b000 || nonlinear_s_rdy !== 3'b000) begin fails++; $display("[TB] FAIL reset_nl got m=%b s=%b expected 000/000", nonlinear_m_val, nonlinear_s_rdy); end
        tests++; if (stage_done !== 3'b000 || err !== 1'b0) begin fails++; $display("[TB] FAIL reset_done_err got done=%b err=%b expected 000/0", stage_done, err); end
    endtask

    task automatic test_basic_prd();
        accept(3'b001, 10'd5);
        tests++; if (busy !== 1'b1 || stage_rdy !== 3'b000) begin fails++; $display("[TB] FAIL prd_accept got busy=%b rdy=%b expected 1/000", busy, stage_rdy); end
        watch(50, 0, 0, 3'b001, 3'b000);
        tests++; if (w_tiles !== 4 || w_blk_ok !== 1'b1) begin fails++; $display("[TB] FAIL prd_blocks got %0d ok=%b expected 4 ok=1", w_tiles, w_blk_ok); end
        tests++; if (w_mcnt !== 1 || w_mval !== 3'b001) begin fails++; $display("[TB] FAIL prd_mval got %0d cyc %b expected 1 cyc 001", w_mcnt, w_mval); end
        tests++; if (w_done_cnt !== 1 || w_done_val !== 3'b001) begin fails++; $display("[TB] FAIL prd_done got cnt=%0d val=%b expected 1/001", w_done_cnt, w_done_val); end
        tests++; if (w_done_edge !== 7) begin fails++; $display("[TB] FAIL prd_latency got %0d expected 7", w_done_edge); end
        tests++; if (stage_rdy !== 3'b111 || busy !== 1'b0 || w_rdy_bad !== 1'b0) begin fails++; $display("[TB] FAIL prd_idle got rdy=%b busy=%b bad=%b expected 111/0/0", stage_rdy, busy, w_rdy_bad); end
    endtask

    task automatic test_priority();
        accept(3'b110, 10'd1);
        watch(50, 0, 0, 3'b111, 3'b001);
        tests++; if (w_mval !== 3'b010) begin fails++; $display("[TB] FAIL prio_mval got %b expected 010", w_mval); end
        tests++; if (w_done_cnt !== 1 || w_done_val !== 3'b010) begin fails++; $display("[TB] FAIL prio_done got cnt=%0d val=%b expected 1/010", w_done_cnt, w_done_val); end
        tests++; if (w_tiles !== 2 || w_done_edge !== 5) begin fails++; $display("[TB] FAIL prio_timing got tiles=%0d edge=%0d expected 2/5", w_tiles, w_done_edge); end
        tick();
        tests++; if (busy !== 1'b0 || stage_done !== 3'b000) begin fails++; $display("[TB] FAIL busy_request_ignored got busy=%b done=%b expected 0/000", busy, stage_done); end
    endtask

    task automatic test_backpressure();
        accept(3'b100, 10'd3);
        watch(80, 1, 5, 3'b100, 3'b000);
        tests++; if (w_tiles !== 3 || w_blk_ok !== 1'b1) begin fails++; $display("[TB] FAIL bp_blocks got %0d ok=%b expected 3 ok=1", w_tiles, w_blk_ok); end
        tests++; if (w_mcnt !== 6 || w_mval !== 3'b100) begin fails++; $display("[TB] FAIL bp_mval got %0d cyc %b expected 6 cyc 100", w_mcnt, w_mval); end
        tests++; if (w_done_cnt !== 1 || w_done_edge !== 13) begin fails++; $display("[TB] FAIL bp_done got cnt=%0d edge=%0d expected 1/13", w_done_cnt, w_done_edge); end
    endtask

    task automatic test_boundaries();
        accept(3'b001, 10'd0);
        watch(50, 0, 0, 3'b001, 3'b000);
        tests++; if (w_tiles !== 1 || w_done_edge !== 4) begin fails++; $display("[TB] FAIL lm0_blocks got tiles=%0d edge=%0d expected 1/4", w_tiles, w_done_edge); end
        accept(3'b010, 10'd700);
        watch(400, 0, 0, 3'b010, 3'b000);
        tests++; if (w_tiles !== 251 || w_blk_ok !== 1'b1) begin fails++; $display("[TB] FAIL clamp_blocks got %0d ok=%b expected 251 ok=1", w_tiles, w_blk_ok); end
        tests++; if (w_done_edge !== 254 || w_done_cnt !== 1) begin fails++; $display("[TB] FAIL clamp_latency got edge=%0d cnt=%0d expected 254/1", w_done_edge, w_done_cnt); end
    endtask

    task automatic test_reset_mid_issue();
        int done_seen;
        done_seen = 0;
        accept(3'b001, 10'd100);
        tile_rdy = 1'b1;
        tick(); tick(); tick();
        tests++; if (tile_val !== 1'b1 || blk_idx !== 10'd3) begin fails++; $display("[TB] FAIL mid_issue got val=%b idx=%0d expected 1/3", tile_val, blk_idx); end
        #2;
        sys_rst = 1'b0;
        #1;
        tests++; if (tile_val !== 1'b0 || blk_idx !== 10'd0 || busy !== 1'b0 || stage_rdy !== 3'b111) begin fails++; $display("[TB] FAIL async_reset got val=%b idx=%0d busy=%b rdy=%b expected 0/0/0/111", tile_val, blk_idx, busy, stage_rdy); end
        idle_inputs();
        tick(); tick();
        sys_rst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (stage_done != 3'b000 || busy) done_seen++;
        end
        tests++; if (done_seen !== 0) begin fails++; $display("[TB] FAIL reset_no_done got %0d active cycles expected 0", done_seen); end
    endtask

    task automatic test_timeout();
        accept(3'b001, 10'd0);
        watch(40, 0, 0, 3'b000, 3'b000);
`ifdef RSA_STAGE_TIMEOUT_EN
        tests++; if (w_err_edge !== 17 || w_done_cnt !== 0) begin fails++; $display("[TB] FAIL timeout_err got edge=%0d done=%0d expected 17/0", w_err_edge, w_done_cnt); end
        tests++; if (stage_rdy !== 3'b111 || busy !== 1'b0 || err !== 1'b1) begin fails++; $display("[TB] FAIL timeout_idle got rdy=%b busy=%b err=%b expected 111/0/1", stage_rdy, busy, err); end
        tick(); tick();
        tests++; if (err !== 1'b1) begin fails++; $display("[TB] FAIL err_sticky got %b expected 1", err); end
`else
        tests++; if (w_err_edge !== -1 || w_done_cnt !== 0 || err !== 1'b0) begin fails++; $display("[TB] FAIL nowd_err got edge=%0d done=%0d err=%b expected -1/0/0", w_err_edge, w_done_cnt, err); end
        tests++; if (busy !== 1'b1 || nonlinear_s_rdy !== 3'b001) begin fails++; $display("[TB] FAIL nowd_wait got busy=%b s_rdy=%b expected 1/001", busy, nonlinear_s_rdy); end
        nonlinear_s_val = 3'b001;
        tick();
        nonlinear_s_val = 3'b000;
        tests++; if (stage_done !== 3'b001) begin fails++; $display("[TB] FAIL nowd_done got %b expected 001", stage_done); end
        tick();
        tests++; if (stage_rdy !== 3'b111 || stage_done !== 3'b000) begin fails++; $display("[TB] FAIL nowd_idle got rdy=%b done=%b expected 111/000", stage_rdy, stage_done); end
`endif
    endtask

    initial begin
        sys_rst = 1'b1;
        idle_inputs();
        landmark_num = '0;
        #1;
        test_reset();
        test_basic_prd();
        test_priority();
        test_backpressure();
        test_boundaries();
        test_reset_mid_issue();
        test_timeout();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/rsa_stage_seq.md
Name: rsa_stage_seq

Overview:
Parametrised stage sequencer for the reconfigurable systolic array (RSA). It generalises the fixed 3-stage PRD/NEW/UPD val/rdy control to STAGE_NUM one-hot stages, each with its own nonlinear channel. On an accepted stage request it sweeps the covariance row-blocks through the array tile port, then performs the nonlinear-unit send/receive handshake and pulses stage_done. It sits between the EKF top-level scheduler and the RSA datapath and nonlinear units.

Parameters:
STAGE_NUM, 3, number of one-hot stages and nonlinear channels (bit 0 = PRD, bit 1 = NEW, bit 2 = UPD)
BLK, 4, array tile edge in rows; must be a power of two
ROW_LEN, 10, width of landmark_num and blk_idx
MAX_LANDMARK, 500, landmark_num clamp value
TIMEOUT_W, 8, watchdog counter width (optional feature only)

Ports:
clk  in  1  system clock, rising edge
sys_rst  in  1  asynchronous, active-low reset
landmark_num  in  ROW_LEN  current landmark count, sampled on stage accept
stage_val  in  STAGE_NUM  one-hot stage request
stage_rdy  out  STAGE_NUM  stage accept-ready, all bits equal
tile_val  out  1  block-issue valid to the RSA datapath
tile_rdy  in  1  RSA datapath ready for a block
blk_idx  out  ROW_LEN  index of the block being issued
nonlinear_m_val  out  STAGE_NUM  send valid to nonlinear channel
nonlinear_m_rdy  in  STAGE_NUM  nonlinear channel ready
nonlinear_s_val  in  STAGE_NUM  nonlinear result valid
nonlinear_s_rdy  out  STAGE_NUM  result accept-ready
stage_done  out  STAGE_NUM  1-cycle completion pulse for the stage that ran
busy  out  1  high whenever the FSM is not in IDLE
err  out  1  sticky timeout flag (optional feature only)

Behaviour:
- Reset: the FSM goes to IDLE and all counters clear. Reset values: stage_rdy = all 1s, blk_idx = 0, busy = 0, err = 0, and all other outputs 0. Reset is asynchronous: asserting it mid-operation aborts immediately, and no stage_done pulse is produced.
- States: IDLE -> ISSUE -> NL_SEND -> NL_RECV -> DONE -> IDLE.
- IDLE:
  - stage_rdy is all 1s.
  - A request is accepted on a cycle with any stage_val bit high. If several bits are high, the lowest index wins.
  - On accept, the winning index is latched as sel (one-hot) and nlm = min(landmark_num, MAX_LANDMARK) is latched.
  - nblk = (3 + 2*nlm + BLK - 1) >> log2(BLK), computed at ROW_LEN+2 bits. nlm = 0 gives nblk = 1.
  - Next state is ISSUE, with blk_idx = 0.
- Outside IDLE: stage_rdy is all 0s and stage_val is ignored.
- ISSUE:
  - tile_val = 1 and blk_idx holds the current block.
  - On tile_val & tile_rdy, blk_idx increments.
  - On the handshake with blk_idx = nblk-1, the next state is NL_SEND. tile_val drops the following cycle.
  - When tile_rdy is held high, blocks issue back-to-back, one per cycle.
- NL_SEND: nonlinear_m_val = sel. When nonlinear_m_rdy[sel] is high, the next state is NL_RECV. Bits of nonlinear_m_rdy other than sel are ignored.
- NL_RECV: nonlinear_s_rdy = sel. When nonlinear_s_val[sel] is high, the next state is DONE. An s_val arriving before NL_RECV is not remembered; the channel must hold it.
- DONE: stage_done = sel for exactly 1 cycle, then IDLE. stage_rdy returns high in the cycle after DONE.
- Minimum latency from the accept edge to the stage_done pulse, with all handshakes ready immediately: nblk + 3 cycles.
- busy = (state != IDLE).

Optional Feature:
RSA_STAGE_TIMEOUT_EN:
- Defined:
  - A TIMEOUT_W-bit counter clears on entry to NL_SEND and NL_RECV and increments on each cycle spent waiting in those states.
  - When it reaches 2^TIMEOUT_W - 1, err is set (sticky until reset), the FSM returns to IDLE, and no stage_done pulse is produced.
- Undefined: no counter is built, err is tied to 0, and the FSM waits indefinitely.

Test Plan:
- Reset values: hold sys_rst low for 2 cycles, then release -> stage_rdy = 3'b111, busy = 0, all other outputs 0.
- Basic PRD run: landmark_num = 5, stage_val = 3'b001 for 1 cycle, tile_rdy tied to 1, m_rdy[0] and s_val[0] tied to 1 -> blk_idx steps 0,1,2,3, nonlinear_m_val = 3'b001 for 1 cycle, stage_done = 3'b001 exactly 7 cycles after the accept edge.
- Simultaneous requests: stage_val = 3'b110 -> NEW is selected, nonlinear_m_val = 3'b010, and UPD is ignored. A new request while busy gets no response.
- Back-pressure: tile_rdy toggling 1,0,1,0 and nonlinear_m_rdy[2] delayed 5 cycles -> blk_idx advances only on handshake cycles, m_val stays high for 6 cycles, and stage_done is still a single pulse.
- Boundaries:
  - landmark_num = 0 -> exactly one block.
  - landmark_num = 700 -> clamped to 500, giving nblk = 251.
  - Assert sys_rst mid-ISSUE -> outputs return to reset values immediately and no stage_done pulse.
- Timeout, with RSA_STAGE_TIMEOUT_EN and TIMEOUT_W = 4: never assert nonlinear_s_val -> err = 1 after 15 waiting cycles in NL_RECV, FSM back in IDLE with stage_rdy = 3'b111, no stage_done pulse.
